qsn_ctrl_85b: RTL and testbench

//  Control-side initiator for the 85-bit QSN circular shifter (qsn_top_85b); the shifter needs an external driver for its selects.

---
 rtl/qsn_ctrl_85b_pkg.sv | 33 +++
 rtl/qsn_ctrl_85b_cmd_fifo.sv | 46 ++++
 rtl/qsn_ctrl_85b.sv | 160 ++++++++++++++++
 tb/tb_qsn_ctrl_85b.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/qsn_ctrl_85b_pkg.sv
// Shared constants, command layout and helpers for the 85-bit QSN select controller.
package qsn_ctrl_85b_pkg;

    localparam int QSN_Z       = 85;
    localparam int QSN_SEL_W   = 7;
    localparam int QSN_MERGE_W = 84;
    localparam int QSN_CMD_W   = QSN_SEL_W + 2;

    localparam logic [QSN_SEL_W-1:0] QSN_Z_SEL = QSN_SEL_W'(QSN_Z);

    typedef struct packed {
        logic [QSN_SEL_W-1:0] shift;
        logic                 inverse;
        logic                 last;
    } qsn_cmd_t;

    // The pipelined shifter schedule (SCHED_4_6) adds one register stage to the data path.
    function automatic int qsn_lat_for_sched(input bit sched_4_6);
        return sched_4_6 ? 1 : 0;
    endfunction

    // Thermometer code: bit k set while k < Z - s_eff; set bits steer the left network.
    function automatic logic [QSN_MERGE_W-1:0] qsn_thermo(input logic [QSN_SEL_W-1:0] s_eff);
        logic [QSN_MERGE_W-1:0] m;
        logic [QSN_SEL_W-1:0]   lim;
        lim = QSN_Z_SEL - s_eff;
        for (int k = 0; k < QSN_MERGE_W; k++) begin
            m[k] = (QSN_SEL_W'(k) < lim);
        end
        return m;
    endfunction

endpackage

// File: rtl/qsn_ctrl_85b_cmd_fifo.sv
// Small synchronous command FIFO; full/empty come from comparing the extra pointer MSB.
module qsn_ctrl_85b_cmd_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    // Storage needs no reset: the pointers define which entries are meaningful.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/qsn_ctrl_85b.sv
// Select generator for qsn_top_85b: command FIFO -> stage A (shift reduction/inversion)
// -> stage B (registered selects) -> data-valid delay line matching the shifter latency.
module qsn_ctrl_85b
    import qsn_ctrl_85b_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int QSN_LAT    = 0
) (
    input  logic                   sys_clk,
    input  logic                   rstn,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [QSN_SEL_W-1:0]   cmd_shift,
    input  logic                   cmd_inverse,
    input  logic                   cmd_last,
    output logic                   sel_valid,
    input  logic                   sel_ready,
    output logic [QSN_SEL_W-1:0]   left_sel,
    output logic [QSN_SEL_W-1:0]   right_sel,
    output logic [QSN_MERGE_W-1:0] merge_sel,
    output logic                   sel_last,
    output logic                   qsn_out_vld,
    output logic                   qsn_out_lst,
    output logic                   range_err
);

    qsn_cmd_t               push_cmd;
    qsn_cmd_t               pop_cmd;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_pop;
    logic                   ready_q;

    logic                   a_valid_q;
    logic                   a_last_q;
    logic [QSN_SEL_W-1:0]   a_seff_q;
    logic [QSN_SEL_W-1:0]   s_red_d;
    logic [QSN_SEL_W-1:0]   s_eff_d;
    logic                   range_err_q;

    logic                   b_valid_q;
    logic                   b_last_q;
    logic [QSN_SEL_W-1:0]   left_q;
    logic [QSN_SEL_W-1:0]   right_q;
    logic [QSN_MERGE_W-1:0] merge_q;
    logic [QSN_SEL_W-1:0]   right_d;
    logic [QSN_MERGE_W-1:0] merge_d;

    logic                   b_en;
    logic                   a_en;
    logic                   fire;

    assign push_cmd  = '{shift: cmd_shift, inverse: cmd_inverse, last: cmd_last};
    assign cmd_ready = ready_q && !fifo_full;

    qsn_ctrl_85b_cmd_fifo #(
        .WIDTH (QSN_CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk_i   (sys_clk),
        .rst_ni  (rstn),
        .push_i  (cmd_valid && cmd_ready),
        .wdata_i (push_cmd),
        .pop_i   (fifo_pop),
        .rdata_o (pop_cmd),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Enable-gated back-pressure: a stage advances only when the one after it can take data.
    assign b_en     = !b_valid_q || sel_ready;
    assign a_en     = !a_valid_q || b_en;
    assign fifo_pop = a_en && !fifo_empty;
    assign fire     = b_valid_q && sel_ready;

    // A single subtract suffices because the 7-bit shift never reaches 2*Z.
    always_comb begin
        s_red_d = (pop_cmd.shift >= QSN_Z_SEL) ? pop_cmd.shift - QSN_Z_SEL : pop_cmd.shift;
        s_eff_d = (pop_cmd.inverse && (s_red_d != '0)) ? QSN_Z_SEL - s_red_d : s_red_d;
    end

    always_comb begin
        right_d = (a_seff_q == '0) ? '0 : QSN_Z_SEL - a_seff_q;
        merge_d = qsn_thermo(a_seff_q);
    end

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            ready_q     <= 1'b0;
            a_valid_q   <= 1'b0;
            a_last_q    <= 1'b0;
            a_seff_q    <= '0;
            range_err_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            if (a_en) begin
                a_valid_q <= fifo_pop;
                if (fifo_pop) begin
                    a_last_q <= pop_cmd.last;
                    a_seff_q <= s_eff_d;
                end
            end
            if (fifo_pop && (pop_cmd.shift >= QSN_Z_SEL)) range_err_q <= 1'b1;
        end
    end

    // Selects only update on a real beat so they hold between beats.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            b_valid_q <= 1'b0;
            b_last_q  <= 1'b0;
            left_q    <= '0;
            right_q   <= '0;
            merge_q   <= '0;
        end else if (b_en) begin
            b_valid_q <= a_valid_q;
            b_last_q  <= a_valid_q && a_last_q;
            if (a_valid_q) begin
                left_q  <= a_seff_q;
                right_q <= right_d;
                merge_q <= merge_d;
            end
        end
    end

    assign sel_valid = b_valid_q;
    assign sel_last  = b_last_q;
    assign left_sel  = left_q;
    assign right_sel = right_q;
    assign merge_sel = merge_q;
    assign range_err = range_err_q;

    generate
        if (QSN_LAT == 0) begin : g_lat0
            assign qsn_out_vld = fire;
            assign qsn_out_lst = b_last_q;
        end else begin : g_latn
            logic [QSN_LAT-1:0] vld_dly_q;
            logic [QSN_LAT-1:0] lst_dly_q;

            always_ff @(posedge sys_clk or negedge rstn) begin
                if (!rstn) begin
                    vld_dly_q <= '0;
                    lst_dly_q <= '0;
                end else begin
                    vld_dly_q[0] <= fire;
                    lst_dly_q[0] <= fire && b_last_q;
                    for (int i = 1; i < QSN_LAT; i++) begin
                        vld_dly_q[i] <= vld_dly_q[i-1];
                        lst_dly_q[i] <= lst_dly_q[i-1];
                    end
                end
            end

            assign qsn_out_vld = vld_dly_q[QSN_LAT-1];
            assign qsn_out_lst = lst_dly_q[QSN_LAT-1];
        end
    endgenerate

endmodule

// File: tb/tb_qsn_ctrl_85b.sv
// Scoreboard bench for qsn_ctrl_85b: a zero-latency and a one-cycle-latency instance share stimulus.
module tb_qsn_ctrl_85b;
    import qsn_ctrl_85b_pkg::*;

    logic        sys_clk = 1'b0;
    logic        rstn;
    logic        cmd_valid;
    logic [6:0]  cmd_shift;
    logic        cmd_inverse;
    logic        cmd_last;
    logic        sel_ready;

    logic        cmd_ready0, sel_valid0, sel_last0, vld0, lst0, rerr0;
    logic [6:0]  left0, right0;
    logic [83:0] merge0;
    logic        cmd_ready1, sel_valid1, sel_last1, vld1, lst1, rerr1;
    logic [6:0]  left1, right1;
    logic [83:0] merge1;

    typedef struct packed {
        logic [6:0]  l;
        logic [6:0]  r;
        logic [83:0] m;
        logic        last;
    } beat_t;

    beat_t sb_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    beat_cnt = 0;
    int    rdy_mode = 0;
    logic  prev_fire = 1'b0;
    logic  prev_last = 1'b0;

    always #5 sys_clk = ~sys_clk;

    qsn_ctrl_85b #(.FIFO_DEPTH(4), .QSN_LAT(0)) dut0 (
        .sys_clk(sys_clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready0),
        .cmd_shift(cmd_shift), .cmd_inverse(cmd_inverse), .cmd_last(cmd_last),
        .sel_valid(sel_valid0), .sel_ready(sel_ready), .left_sel(left0), .right_sel(right0),
        .merge_sel(merge0), .sel_last(sel_last0), .qsn_out_vld(vld0), .qsn_out_lst(lst0),
        .range_err(rerr0)
    );

    qsn_ctrl_85b #(.FIFO_DEPTH(4), .QSN_LAT(1)) dut1 (
        .sys_clk(sys_clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready1),
        .cmd_shift(cmd_shift), .cmd_inverse(cmd_inverse), .cmd_last(cmd_last),
        .sel_valid(sel_valid1), .sel_ready(sel_ready), .left_sel(left1), .right_sel(right1),
        .merge_sel(merge1), .sel_last(sel_last1), .qsn_out_vld(vld1), .qsn_out_lst(lst1),
        .range_err(rerr1)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic beat_t model(input logic [6:0] s, input logic inv, input logic last);
        int    sp;
        int    se;
        beat_t b;
        sp = (int'(s) >= 85) ? int'(s) - 85 : int'(s);
        se = inv ? ((sp == 0) ? 0 : 85 - sp) : sp;
        b.l = 7'(se);
        b.r = 7'((se == 0) ? 0 : 85 - se);
        for (int k = 0; k < 84; k++) b.m[k] = (k < 85 - se);
        b.last = last;
        return b;
    endfunction

    always @(posedge sys_clk) begin
        #1;
        case (rdy_mode)
            0:       sel_ready = 1'b1;
            1:       sel_ready = 1'($urandom_range(0, 1));
            default: sel_ready = 1'b0;
        endcase
    end

    // Monitor: samples mid-cycle, pops the scoreboard on each fire, pushes on each accept.
    always @(negedge sys_clk) begin
        if (!rstn) begin
            prev_fire = 1'b0;
            prev_last = 1'b0;
        end else begin
            logic  fire0;
            beat_t e;
            fire0 = sel_valid0 && sel_ready;
            chk("lat0_vld", 128'(vld0), 128'(fire0));
            chk("lat1_vld", 128'(vld1), 128'(prev_fire));
            chk("lat1_lst", 128'(lst1), 128'(prev_last));
            if (fire0) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_beat", 128'(1), 128'(0));
                end else begin
                    e = sb_q.pop_front();
                    chk("left_sel", 128'(left0), 128'(e.l));
                    chk("right_sel", 128'(right0), 128'(e.r));
                    chk("merge_sel", 128'(merge0), 128'(e.m));
                    chk("sel_last", 128'(sel_last0), 128'(e.last));
                    chk("lat0_lst", 128'(lst0), 128'(e.last));
                end
                beat_cnt++;
                $display("beat %0d: left=%0d right=%0d merge=%h last=%0b",
                         beat_cnt, left0, right0, merge0, sel_last0);
            end
            prev_fire = fire0;
            prev_last = fire0 && sel_last0;
            if (cmd_valid && cmd_ready0) sb_q.push_back(model(cmd_shift, cmd_inverse, cmd_last));
        end
    end

    task automatic send(input logic [6:0] s, input logic inv, input logic last);
        int waited = 0;
        cmd_shift   = s;
        cmd_inverse = inv;
        cmd_last    = last;
        cmd_valid   = 1'b1;
        forever begin
            @(negedge sys_clk);
            if (cmd_ready0) break;
            waited++;
            if (waited > 300) begin
                chk("accept_timeout", 128'(0), 128'(1));
                break;
            end
        end
        @(posedge sys_clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 500) begin
            @(posedge sys_clk);
            #1;
            n++;
        end
        chk("drain_left", 128'(sb_q.size()), 128'(0));
        repeat (3) @(posedge sys_clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [83:0] ones84;
        logic [83:0] t3_merge;
        logic [6:0]  hold_l;
        logic [83:0] hold_m;
        int          beats_before;
        ones84   = '1;
        t3_merge = 84'h3FF;

        rstn = 1'b0; cmd_valid = 1'b0; cmd_shift = '0; cmd_inverse = 1'b0;
        cmd_last = 1'b0; sel_ready = 1'b1;
        #2;
        chk("rst_cmd_ready", 128'(cmd_ready0), 128'(0));
        chk("rst_sel_valid", 128'(sel_valid0), 128'(0));
        chk("rst_merge", 128'(merge0), 128'(0));
        chk("rst_range_err", 128'(rerr0), 128'(0));
        repeat (3) @(posedge sys_clk);
        #1;
        rstn = 1'b1;
        chk("ready_at_release", 128'(cmd_ready0), 128'(0));
        @(posedge sys_clk);
        #1;
        chk("ready_after_clk", 128'(cmd_ready0), 128'(1));

        // T1: forward shift of 1, latency and exact select values
        send(7'd1, 1'b0, 1'b0);
        chk("t1_cyc0_valid", 128'(sel_valid0), 128'(0));
        @(posedge sys_clk); #1;
        chk("t1_cyc1_valid", 128'(sel_valid0), 128'(0));
        @(posedge sys_clk); #1;
        chk("t1_cyc2_valid", 128'(sel_valid0), 128'(1));
        chk("t1_left", 128'(left0), 128'(1));
        chk("t1_right", 128'(right0), 128'(84));
        chk("t1_merge", 128'(merge0), 128'(ones84));
        drain();

        // T2: zero shifts, then modulo reduction and sticky range error
        send(7'd0, 1'b0, 1'b0);
        send(7'd0, 1'b1, 1'b0);
        drain();
        chk("t2_merge_hold", 128'(merge0), 128'(ones84));
        chk("t2_range_err0", 128'(rerr0), 128'(0));
        send(7'd85, 1'b0, 1'b0);
        send(7'd127, 1'b1, 1'b0);
        drain();
        chk("t2_range_err1", 128'(rerr0), 128'(1));

        // T3: inverse 10; selects hold after the beat
        send(7'd10, 1'b1, 1'b0);
        drain();
        chk("t3_left", 128'(left0), 128'(75));
        chk("t3_right", 128'(right0), 128'(10));
        chk("t3_merge", 128'(merge0), 128'(t3_merge));

        // Random burst with random back-pressure
        rdy_mode = 1;
        for (int i = 0; i < 24; i++) begin
            send(7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)), (i % 5) == 4);
        end
        drain();

        // T4: fill FIFO and pipeline under stall, then release
        rdy_mode = 2;
        @(posedge sys_clk); #1;
        beats_before = beat_cnt;
        for (int i = 0; i < 6; i++) send(7'(i * 13 + 3), 1'(i % 2), i == 5);
        chk("t4_full_ready", 128'(cmd_ready0), 128'(0));
        hold_l = left0;
        hold_m = merge0;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("t4_stall_valid", 128'(sel_valid0), 128'(1));
        chk("t4_stall_left", 128'(left0), 128'(hold_l));
        chk("t4_stall_merge", 128'(merge0), 128'(hold_m));
        rdy_mode = 0;
        drain();
        chk("t4_beat_count", 128'(beat_cnt - beats_before), 128'(6));

        // T5: three commands, last on the third
        for (int i = 0; i < 3; i++) send(7'(20 + i), 1'b0, i == 2);
        drain();

        // T6: reset with commands queued
        rdy_mode = 2;
        @(posedge sys_clk); #1;
        for (int i = 0; i < 3; i++) send(7'(40 + i), 1'b0, 1'b0);
        repeat (2) @(posedge sys_clk);
        #1;
        rstn = 1'b0;
        #1;
        sb_q.delete();
        chk("t6_sel_valid", 128'(sel_valid0), 128'(0));
        chk("t6_left", 128'(left0), 128'(0));
        chk("t6_right", 128'(right0), 128'(0));
        chk("t6_merge", 128'(merge0), 128'(0));
        chk("t6_range_err", 128'(rerr0), 128'(0));
        chk("t6_cmd_ready", 128'(cmd_ready0), 128'(0));
        chk("t6_lat1_vld", 128'(vld1), 128'(0));
        beats_before = beat_cnt;
        repeat (3) @(posedge sys_clk);
        #1;
        rstn = 1'b1;
        rdy_mode = 0;
        repeat (10) @(posedge sys_clk);
        #1;
        chk("t6_no_stale", 128'(beat_cnt), 128'(beats_before));
        chk("t6_idle_valid", 128'(sel_valid0), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
